imm_gen_stage: RTL

- Pipelined, parametrised successor to the combinational immediate decoder, placed between fetch and decode/execute.
- Accepts one 32-bit RV instruction per cycle on a valid/ready handshake.
- Auto-selects the immediate format from the opcode and emits a single XLEN-wide sign-extended immediate, a format code and a shift amount.
- Flags illegal/unsupported opcodes and keeps a saturating count of them; an optional skid buffer breaks the ready path.

---
 rtl/imm_gen_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Pipelined RV immediate generator stage.
// Decodes one instruction per cycle on a valid/ready handshake. It produces the sign-extended
// immediate, a format code, the shift amount, an illegal flag and a saturating illegal count.
// An optional one-entry skid buffer makes in_ready a registered signal.
module imm_gen_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned SKID  = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [5:0]       out_shamt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [2:0] FmtNone = 3'd0;
   localparam logic [2:0] FmtI    = 3'd1;
   localparam logic [2:0] FmtS    = 3'd2;
   localparam logic [2:0] FmtB    = 3'd3;
   localparam logic [2:0] FmtU    = 3'd4;
   localparam logic [2:0] FmtJ    = 3'd5;
   localparam logic [2:0] FmtSh   = 3'd6;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic [5:0]      shamt;
      logic            illegal;
   } res_t;

   res_t             dec;
   res_t             out_q, out_d;
   res_t             skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             ready_q, ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [5:0] shamt;
   logic       in_xfer;
   logic       out_xfer;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   // RV32 shifts only use a 5-bit amount; bit 25 is reported separately as illegal
   assign shamt    = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

   assign in_ready = (SKID != 0) ? ready_q : (!out_valid_q || out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   // Decode the incoming instruction into its result record
   always_comb begin
      dec.instr   = in_instr;
      dec.imm     = '0;
      dec.fmt     = FmtNone;
      dec.shamt   = shamt;
      dec.illegal = 1'b0;
      case (opcode)
         7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
            dec.fmt = FmtI;
            dec.imm = XLEN'($signed(in_instr[31:20]));
         end
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.fmt     = FmtSh;
               dec.imm     = XLEN'(shamt);
               dec.illegal = (XLEN == 32) && in_instr[25];
            end else begin
               dec.fmt = FmtI;
               dec.imm = XLEN'($signed(in_instr[31:20]));
            end
         end
         7'b0100011: begin
            dec.fmt = FmtS;
            dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         7'b1100011: begin
            dec.fmt = FmtB;
            dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt = FmtU;
            dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         7'b1101111: begin
            dec.fmt = FmtJ;
            dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
         end
         7'b0110011: begin
            dec.fmt = FmtNone;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Next-state for the output register, skid entry, ready flop and illegal counter
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;

      if (SKID == 0) begin
         if (in_xfer) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else if (out_xfer) begin
            out_valid_d = 1'b0;
         end
      end else begin
         if (skid_valid_q) begin
            // in_ready is low here, so only draining can happen
            if (out_xfer) begin
               out_d        = skid_q;
               out_valid_d  = 1'b1;
               skid_valid_d = 1'b0;
            end
         end else if (in_xfer) begin
            if (!out_valid_q || out_ready) begin
               out_d       = dec;
               out_valid_d = 1'b1;
            end else begin
               skid_d       = dec;
               skid_valid_d = 1'b1;
            end
         end else if (out_xfer) begin
            out_valid_d = 1'b0;
         end
      end

      ready_d = !skid_valid_d;

      if (out_xfer && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State update; rst clears everything including in-flight and skid contents
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_q.instr;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_shamt   = out_q.shamt;
   assign out_illegal = out_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule
